colisor_tiro: RTL

COLISOR_TIRO -- requirements
Module: colisor_tiro

---
 rtl/colisor_tiro.sv | 137 +++++++++++++
 1 files changed

// File: rtl/colisor_tiro.sv
// Shot/collision checker for a two-player naval board: ship loading, hit detection, remaining cells.
// Define COLISOR_REPEAT_HIT_EN to report a repeat shot on an already-hit ship cell as a hit.
module colisor_tiro #(
  parameter int unsigned GRID = 9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       wr_en,
  input  logic       wr_player,
  input  logic [3:0] wr_x,
  input  logic [3:0] wr_y,
  input  logic       ready,
  input  logic       jogador,
  input  logic [3:0] coord_tiroX,
  input  logic [3:0] coord_tiroY,
  output logic       acertou_tiro,
  output logic       valid,
  output logic       busy,
  output logic [3:0] qtd_P1,
  output logic [3:0] qtd_P2
);

  localparam int unsigned Cells = GRID * GRID;
  localparam int unsigned IdxW  = (Cells > 1) ? $clog2(Cells) : 1;

  typedef enum logic [1:0] {StIdle, StCheck, StHold} state_e;

  state_e           state_q;
  logic             ready_q;
  logic             shot_player_q;
  logic [3:0]       shot_x_q;
  logic [3:0]       shot_y_q;
  // Index 0 is player 1, index 1 is player 2.
  logic [Cells-1:0] occ_q [2];
  logic [Cells-1:0] hit_q [2];
  logic [3:0]       qtd_q [2];

  logic            rise;
  logic            wr_ok;
  logic [IdxW-1:0] wr_idx;
  logic [IdxW-1:0] shot_idx;
  logic            target;
  logic            shot_occ;
  logic            shot_hit;

  function automatic logic in_range(input logic [3:0] c);
    return (c != 4'd0) && (32'(c) <= GRID);
  endfunction

  function automatic logic [IdxW-1:0] cell_idx(input logic [3:0] x, input logic [3:0] y);
    int unsigned i;
    i = (32'(y) - 32'd1) * GRID + (32'(x) - 32'd1);
    return i[IdxW-1:0];
  endfunction

  always_comb begin
    rise     = ready && !ready_q;
    wr_idx   = cell_idx(wr_x, wr_y);
    shot_idx = cell_idx(shot_x_q, shot_y_q);
    // A shooter always aims at the opponent's board.
    target   = ~shot_player_q;
    wr_ok    = (state_q == StIdle) && wr_en && !rise && in_range(wr_x) && in_range(wr_y) &&
               !occ_q[wr_player][wr_idx];
    shot_occ = in_range(shot_x_q) && in_range(shot_y_q) && occ_q[target][shot_idx];
    shot_hit = shot_occ && !hit_q[target][shot_idx];
  end

`ifdef COLISOR_REPEAT_HIT_EN
  logic shot_repeat;
  assign shot_repeat = shot_occ && hit_q[target][shot_idx];
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      ready_q       <= 1'b0;
      shot_player_q <= 1'b0;
      shot_x_q      <= 4'd0;
      shot_y_q      <= 4'd0;
      occ_q         <= '{default: '0};
      hit_q         <= '{default: '0};
      qtd_q         <= '{default: '0};
      acertou_tiro  <= 1'b0;
      valid         <= 1'b0;
    end else if (clear) begin
      state_q      <= StIdle;
      // Track ready so a level held across the clear is not taken as a new shot.
      ready_q      <= ready;
      occ_q        <= '{default: '0};
      hit_q        <= '{default: '0};
      qtd_q        <= '{default: '0};
      acertou_tiro <= 1'b0;
      valid        <= 1'b0;
    end else begin
      ready_q <= ready;
      case (state_q)
        StIdle: begin
          if (rise) begin
            shot_player_q <= jogador;
            shot_x_q      <= coord_tiroX;
            shot_y_q      <= coord_tiroY;
            state_q       <= StCheck;
          end else if (wr_ok) begin
            occ_q[wr_player][wr_idx] <= 1'b1;
            if (qtd_q[wr_player] != 4'hF) qtd_q[wr_player] <= qtd_q[wr_player] + 4'd1;
          end
        end
        StCheck: begin
          if (shot_hit) begin
            hit_q[target][shot_idx] <= 1'b1;
            if (qtd_q[target] != 4'd0) qtd_q[target] <= qtd_q[target] - 4'd1;
          end
`ifdef COLISOR_REPEAT_HIT_EN
          acertou_tiro <= shot_hit || shot_repeat;
`else
          acertou_tiro <= shot_hit;
`endif
          valid   <= 1'b1;
          state_q <= StHold;
        end
        StHold: begin
          if (!ready) begin
            valid   <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy   = (state_q != StIdle);
  assign qtd_P1 = qtd_q[0];
  assign qtd_P2 = qtd_q[1];

endmodule
